ex_muldiv_seq: RTL and testbench

Multi-cycle RV32M multiply/divide sequencer in the EX stage, alongside the single-cycle ALU datapath. Accepts an M-extension operation with its two register operands. Runs a fixed-latency iterative shift-add multiply or restoring divide on operand magnitudes, then applies sign and RISC-V corner-case fixes. Holds the pipeline with a stall handshake until the result is ready.

---
 rtl/ex_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// An accepted operation runs 32 shift-add (multiply) or restoring (divide)
// steps on operand magnitudes. One FIX cycle applies sign correction and
// divide-by-zero substitution. One DONE cycle then presents the result.
// The latency is fixed for every opcode and operand value.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            stall_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out
);

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

    // Two's-complement negation; |0x80000000| stays 0x80000000 by construction
    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] x);
        return ~x + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    // State and datapath registers
    logic [1:0]        state_q,  state_d;
    logic [5:0]        cnt_q,    cnt_d;
    logic [2:0]        op_q,     op_d;
    logic              sa_q,     sa_d;      // operand A was negative and signed
    logic              sb_q,     sb_d;      // operand B was negative and signed
    logic              dz_q,     dz_d;      // divide by zero captured at acceptance
    logic [XLEN-1:0]   a_q,      a_d;       // |A|: multiplicand, or dividend shifted out MSB first
    logic [XLEN-1:0]   b_q,      b_d;       // |B|: multiplier shifted out LSB first, or divisor
    logic [XLEN-1:0]   rs1_q,    rs1_d;     // raw A for REM by zero
    logic [2*XLEN-1:0] acc_q,    acc_d;     // product, or {remainder, quotient}
    logic [XLEN-1:0]   result_q, result_d;

    // Combinational helpers
    logic              acc_ok_s;
    logic              sign_a_s;
    logic              sign_b_s;
    logic [XLEN:0]     mul_sum_s;
    logic              rem_hi_s;
    logic [XLEN-1:0]   rem_lo_s;
    logic              rem_ge_s;
    logic [XLEN-1:0]   rem_nx_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_result_s;
    logic [1:0]        state_nxt_s;

    // Decode which operands are treated as signed, and their sign at acceptance
    always_comb begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
        case (op_in)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sign_a_s = rs1_in[XLEN-1];
                sign_b_s = rs2_in[XLEN-1];
            end
            OP_MULHSU: begin
                sign_a_s = rs1_in[XLEN-1];
                sign_b_s = 1'b0;
            end
            OP_MULHU, OP_DIVU, OP_REMU: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
            default: begin
                sign_a_s = 1'b0;
                sign_b_s = 1'b0;
            end
        endcase
    end

    // One iteration step for each algorithm, evaluated from the current registers
    always_comb begin
        // Shift-add: add |A| into the high half when the multiplier LSB is set,
        // then shift the whole accumulator right one place.
        if (b_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]};
        end
        // Restoring divide: the partial remainder is shifted left with the next
        // dividend bit. It can reach 33 bits, so the bit shifted out joins the
        // compare. The subtracted value always fits back into 32 bits.
        rem_hi_s = acc_q[2*XLEN-1];
        rem_lo_s = {acc_q[2*XLEN-2:XLEN], a_q[XLEN-1]};
        rem_ge_s = rem_hi_s | (rem_lo_s >= b_q);
        if (rem_ge_s) begin
            rem_nx_s = rem_lo_s - b_q;
        end else begin
            rem_nx_s = rem_lo_s;
        end
    end

    // Sign correction and result selection used in the FIX cycle
    always_comb begin
        if (sa_q ^ sb_q) begin
            prod_s = neg_d(acc_q);
            quo_s  = neg_w(acc_q[XLEN-1:0]);
        end else begin
            prod_s = acc_q;
            quo_s  = acc_q[XLEN-1:0];
        end
        if (sa_q) begin
            rem_s = neg_w(acc_q[2*XLEN-1:XLEN]);
        end else begin
            rem_s = acc_q[2*XLEN-1:XLEN];
        end
        case (op_q)
            OP_MUL:                     fix_result_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (dz_q) begin
                    fix_result_s = {XLEN{1'b1}};
                end else begin
                    fix_result_s = quo_s;
                end
            end
            OP_REM, OP_REMU: begin
                if (dz_q) begin
                    fix_result_s = rs1_q;
                end else begin
                    fix_result_s = rem_s;
                end
            end
            default:                    fix_result_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt_s = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        dz_d        = dz_q;
        a_d         = a_q;
        b_d         = b_q;
        rs1_d       = rs1_q;
        acc_d       = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in && !flush_in) begin
                    op_d        = op_in;
                    sa_d        = sign_a_s;
                    sb_d        = sign_b_s;
                    dz_d        = op_in[2] & (rs2_in == {XLEN{1'b0}});
                    a_d         = sign_a_s ? neg_w(rs1_in) : rs1_in;
                    b_d         = sign_b_s ? neg_w(rs2_in) : rs2_in;
                    rs1_d       = rs1_in;
                    acc_d       = {(2*XLEN){1'b0}};
                    cnt_d       = 6'd0;
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (op_q[2]) begin
                    acc_d = {rem_nx_s, acc_q[XLEN-2:0], rem_ge_s};
                    a_d   = {a_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
                    b_d   = {1'b0, b_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Flush aborts from any state; an aborted operation never updates the result
    always_comb begin
        if (flush_in) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end else if (state_q == ST_FIX) begin
            state_d  = state_nxt_s;
            result_d = fix_result_s;
        end else begin
            state_d  = state_nxt_s;
            result_d = result_q;
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'b000;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            rs1_q    <= {XLEN{1'b0}};
            acc_q    <= {(2*XLEN){1'b0}};
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rs1_q    <= rs1_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Outputs decoded from the state register; the stall also covers the
    // acceptance cycle so the requesting instruction holds in EX.
    always_comb begin
        acc_ok_s   = (state_q == ST_IDLE) & start_in & ~flush_in;
        stall_out  = acc_ok_s | (state_q == ST_CALC) | (state_q == ST_FIX);
        busy_out   = (state_q == ST_CALC) | (state_q == ST_FIX);
        done_out   = (state_q == ST_DONE);
        result_out = result_q;
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M corner cases, randomized
// operations against a plain-arithmetic reference, and latency/abort scenarios.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [2:0]  op_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic        flush_in;
    logic        busy_out;
    logic        stall_out;
    logic        done_out;
    logic [31:0] result_out;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .op_in      (op_in),
        .rs1_in     (rs1_in),
        .rs2_in     (rs2_in),
        .flush_in   (flush_in),
        .busy_out   (busy_out),
        .stall_out  (stall_out),
        .done_out   (done_out),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: RV32M semantics from 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Drives one request in the current cycle (caller is at a falling edge) and
    // runs until done_out or a cycle budget. lat is the cycle of done relative to
    // acceptance. hold_ok records whether stall/busy followed the expected shape.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit hold_ok);
        hold_ok  = 1'b1;
        start_in = 1'b1;
        op_in    = op;
        rs1_in   = a;
        rs2_in   = b;
        #1;
        if (stall_out !== 1'b1 || busy_out !== 1'b0) hold_ok = 1'b0;
        @(negedge clk);
        op_in  = 3'($urandom);
        rs1_in = 32'($urandom);
        rs2_in = 32'($urandom);
        lat    = 1;
        while (done_out !== 1'b1 && lat < 100) begin
            if (stall_out !== 1'b1 || busy_out !== 1'b1) hold_ok = 1'b0;
            start_in = (lat < 32) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            lat++;
        end
        start_in = 1'b0;
        if (stall_out !== 1'b0 || busy_out !== 1'b0) hold_ok = 1'b0;
        res = result_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_in = 1'b0; flush_in = 1'b0;
        op_in = 3'd0; rs1_in = 32'd0; rs2_in = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy_out !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        n_cmp++; if (done_out !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done_out); end
        n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_out); end
        n_cmp++; if (result_out !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", result_out); end
        rst = 1'b0;
    endtask

    task automatic test_mul_timing();
        logic [31:0] res; int lat; bit ok;
        @(negedge clk);
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, ok);
        n_cmp++; if (lat != 34) begin n_err++; $display("FAIL mul_latency: got %0d want 34", lat); end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mul_stall_busy_shape: got bad want good"); end
        n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result: got %h want ffffffeb", res); end
        @(negedge clk);
        n_cmp++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            n_err++; $display("FAIL mul_done_pulse: got done=%b busy=%b want 0 0", done_out, busy_out);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op[13]  = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd6, 3'd4, 3'd6, 3'd5};
        logic [31:0] t_a[13]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd100, 32'd100, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFB,
                                   32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] t_b[13]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                   32'd7, 32'd7, 32'd0, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] t_exp[13] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB,
                                   32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] res; int lat; bit ok;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            do_op(t_op[i], t_a[i], t_b[i], res, lat, ok);
            n_cmp++; if (res !== t_exp[i]) begin
                n_err++; $display("FAIL directed_%0d op=%0d a=%h b=%h: got %h want %h", i, t_op[i], t_a[i], t_b[i], res, t_exp[i]);
            end
            n_cmp++; if (lat != 34 || !ok) begin
                n_err++; $display("FAIL directed_timing_%0d: got lat=%0d shape_ok=%0b want 34 1", i, lat, ok);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp; logic [2:0] op; int lat; bit ok;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom);
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_model(op, a, b);
            @(negedge clk);
            do_op(op, a, b, res, lat, ok);
            n_cmp++; if (res !== exp || lat != 34 || !ok) begin
                n_err++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d ok=%0b want %h lat=34 ok=1",
                                  i, op, a, b, res, lat, ok, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res; int lat; bit ok, seen_done;
        @(negedge clk);
        do_op(3'd0, 32'd2, 32'd3, res, lat, ok);
        n_cmp++; if (res !== 32'd6) begin n_err++; $display("FAIL flush_pre_result: got %h want 00000006", res); end
        @(negedge clk);
        start_in = 1'b1; op_in = 3'd5; rs1_in = 32'd1000; rs2_in = 32'd3;
        @(negedge clk);
        start_in = 1'b0;
        seen_done = 1'b0;
        repeat (9) begin
            if (done_out === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        n_cmp++; if (busy_out !== 1'b0 || stall_out !== 1'b0 || done_out !== 1'b0 || seen_done) begin
            n_err++; $display("FAIL flush_idle: got busy=%b stall=%b done=%b seen_done=%0b want 0 0 0 0",
                              busy_out, stall_out, done_out, seen_done);
        end
        n_cmp++; if (result_out !== 32'd6) begin n_err++; $display("FAIL flush_result_kept: got %h want 00000006", result_out); end
        do_op(3'd0, 32'd3, 32'd4, res, lat, ok);
        n_cmp++; if (res !== 32'd12 || lat != 34 || !ok) begin
            n_err++; $display("FAIL flush_restart: got %h lat=%0d ok=%0b want 0000000c lat=34 ok=1", res, lat, ok);
        end
    endtask

    task automatic test_rst_mid();
        bit seen_done;
        @(negedge clk);
        start_in = 1'b1; op_in = 3'd0; rs1_in = 32'd9; rs2_in = 32'd9;
        @(negedge clk);
        start_in = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy_out !== 1'b0 || stall_out !== 1'b0 || done_out !== 1'b0 || result_out !== 32'd0) begin
            n_err++; $display("FAIL rst_mid: got busy=%b stall=%b done=%b result=%h want 0 0 0 00000000",
                              busy_out, stall_out, done_out, result_out);
        end
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            if (done_out === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen_done) begin n_err++; $display("FAIL rst_mid_discard: got done pulse want none"); end
    endtask

    task automatic test_start_flush();
        bit seen_done;
        @(negedge clk);
        start_in = 1'b1; flush_in = 1'b1; op_in = 3'd0; rs1_in = 32'd5; rs2_in = 32'd5;
        #1;
        n_cmp++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL start_flush_stall: got %b want 0", stall_out); end
        @(negedge clk);
        start_in = 1'b0; flush_in = 1'b0;
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL start_flush_accept: got busy=%b want 0", busy_out); end
        seen_done = 1'b0;
        repeat (40) begin
            if (done_out === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen_done) begin n_err++; $display("FAIL start_flush_done: got done pulse want none"); end
    endtask

    task automatic test_held_start();
        logic [31:0] res; int lat; bit ok;
        @(negedge clk);
        start_in = 1'b1; op_in = 3'd0; rs1_in = 32'd5; rs2_in = 32'd6;
        @(negedge clk);
        lat = 1;
        while (done_out !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != 34 || result_out !== 32'd30) begin
            n_err++; $display("FAIL held_first: got lat=%0d result=%h want 34 0000001e", lat, result_out);
        end
        rs1_in = 32'd7; rs2_in = 32'd8;
        @(negedge clk);
        n_cmp++; if (busy_out !== 1'b0 || stall_out !== 1'b1 || done_out !== 1'b0) begin
            n_err++; $display("FAIL held_idle: got busy=%b stall=%b done=%b want 0 1 0", busy_out, stall_out, done_out);
        end
        do_op(3'd0, 32'd7, 32'd8, res, lat, ok);
        n_cmp++; if (res !== 32'd56 || lat != 34 || !ok) begin
            n_err++; $display("FAIL held_second: got %h lat=%0d ok=%0b want 00000038 lat=34 ok=1", res, lat, ok);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_directed();
        test_random();
        test_flush();
        test_rst_mid();
        test_start_flush();
        test_held_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
